// File: rtl/czf_pkg.sv
// Shared parameters and elaboration-time helpers for the circular zero finder.
// Tree sizing helpers assume a uniform RADIX_N fan-in padded up to RADIX_N**levels leaves.
package czf_pkg;

    localparam int W_DEF     = 32;
    localparam int RADIX_DEF = 4;
    localparam int RADIX_MIN = 2;
    localparam int RADIX_MAX = 8;

    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

    function automatic int czf_pow(input int base, input int e);
        int p;
        p = 1;
        for (int k = 0; k < e; k++) p = p * base;
        return p;
    endfunction

    // ceil(log_radix(w)), at least one level
    function automatic int czf_levels(input int w, input int radix);
        int l;
        int p;
        l = 0;
        p = 1;
        while (p < w) begin
            p = p * radix;
            l = l + 1;
        end
        return (l < 1) ? 1 : l;
    endfunction

    // Index of the first node of tree level 'lvl' when all levels are laid out flat
    function automatic int czf_off(input int leaves, input int radix, input int lvl);
        int off;
        int n;
        off = 0;
        n   = leaves;
        for (int k = 0; k < lvl; k++) begin
            n   = n / radix;
            off = off + n;
        end
        return off;
    endfunction

endpackage

// File: rtl/czf_prienc.sv
// Highest-set-bit priority encoder: one-hot, binary index and any-set flag.
// Purely combinational; flat scan for W <= 8, otherwise a RADIX_N-ary tree.
module czf_prienc
    import czf_pkg::*;
#(
    parameter  int W       = W_DEF,
    parameter  int RADIX_N = RADIX_DEF,
    localparam int EW      = idx_w(W)
) (
    input  logic [W-1:0]  req,
    output logic [W-1:0]  onehot,
    output logic [EW-1:0] enc,
    output logic          any
);

    if (W <= 8) begin : g_flat
        always_comb begin
            any    = 1'b0;
            enc    = '0;
            onehot = '0;
            for (int i = 0; i < W; i++) begin
                if (req[i]) begin
                    any = 1'b1;
                    enc = EW'(i);
                end
            end
            for (int i = 0; i < W; i++) onehot[i] = any && (enc == EW'(i));
        end
    end else begin : g_tree
        localparam int L  = czf_levels(W, RADIX_N);
        localparam int P  = czf_pow(RADIX_N, L);
        localparam int IW = idx_w(P);
        localparam int T  = czf_off(P, RADIX_N, L);

        logic [P-1:0]  req_pad;
        logic [T-1:0]  nd_any;
        logic [IW-1:0] nd_idx [T];

        always_comb begin
            req_pad        = '0;
            req_pad[W-1:0] = req;
        end

        for (genvar l = 0; l < L; l++) begin : g_lvl
            localparam int NN   = P / czf_pow(RADIX_N, l + 1);
            localparam int SPAN = czf_pow(RADIX_N, l);
            localparam int OFF  = czf_off(P, RADIX_N, l);
            localparam int COFF = (l == 0) ? 0 : czf_off(P, RADIX_N, l - 1);

            for (genvar n = 0; n < NN; n++) begin : g_node
                logic [RADIX_N-1:0] c_any;
                logic [IW-1:0]      c_idx [RADIX_N];
                logic [IW-1:0]      sel_idx;

                if (l == 0) begin : g_leaf
                    assign c_any = req_pad[n*RADIX_N +: RADIX_N];
                    for (genvar j = 0; j < RADIX_N; j++) begin : g_c
                        assign c_idx[j] = '0;
                    end
                end else begin : g_inner
                    assign c_any = nd_any[COFF + n*RADIX_N +: RADIX_N];
                    for (genvar j = 0; j < RADIX_N; j++) begin : g_c
                        assign c_idx[j] = nd_idx[COFF + n*RADIX_N + j];
                    end
                end

                // Highest child with a set bit wins; its subtree offset is added to its local index
                always_comb begin
                    sel_idx = '0;
                    for (int j = 0; j < RADIX_N; j++) begin
                        if (c_any[j]) sel_idx = IW'(j * SPAN) + c_idx[j];
                    end
                end

                assign nd_any[OFF + n] = |c_any;
                assign nd_idx[OFF + n] = sel_idx;
            end
        end

        always_comb begin
            any    = nd_any[T-1];
            enc    = EW'(nd_idx[T-1]);
            onehot = '0;
            for (int i = 0; i < W; i++) onehot[i] = nd_any[T-1] && (nd_idx[T-1] == IW'(i));
        end
    end

endmodule

// File: rtl/circ_zero_find.sv
// Circular first-zero finder scanning down from pos_i-1 with wrap; registered, latency 1.
// No backpressure: accepts one request per cycle. Optional SVA under CZF_ASSERT_EN.
module circ_zero_find
    import czf_pkg::*;
#(
    parameter  int W       = W_DEF,
    parameter  int RADIX_N = RADIX_DEF,
    localparam int EW      = idx_w(W)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic          vld_i,
    input  logic [W-1:0]  x_i,
    input  logic [EW-1:0] pos_i,
    output logic          vld_o,
    output logic [W-1:0]  y_o,
    output logic [EW-1:0] y_enc_o,
    output logic          any_o
);

    if (W < 2) begin : g_chk_w
        $error("circ_zero_find: W must be >= 2");
    end
    if (RADIX_N < RADIX_MIN || RADIX_N > RADIX_MAX) begin : g_chk_radix
        $error("circ_zero_find: RADIX_N out of range");
    end

    logic [W-1:0]  free;
    logic [W-1:0]  lo;
    logic [W-1:0]  lo_oh, all_oh, y_d;
    logic [EW-1:0] lo_enc, all_enc, enc_d;
    logic          lo_any, all_any;

    // pos_i >= W sets every mask bit, which selects the same bit as pos_i = 0
    always_comb begin
        free = ~x_i;
        for (int i = 0; i < W; i++) lo[i] = free[i] && (i < int'(pos_i));
    end

    czf_prienc #(.W(W), .RADIX_N(RADIX_N)) u_lo (
        .req    (lo),
        .onehot (lo_oh),
        .enc    (lo_enc),
        .any    (lo_any)
    );

    czf_prienc #(.W(W), .RADIX_N(RADIX_N)) u_all (
        .req    (free),
        .onehot (all_oh),
        .enc    (all_enc),
        .any    (all_any)
    );

    assign y_d   = lo_any ? lo_oh  : all_oh;
    assign enc_d = lo_any ? lo_enc : all_enc;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            vld_o   <= 1'b0;
            y_o     <= '0;
            y_enc_o <= '0;
            any_o   <= 1'b0;
        end else begin
            vld_o <= vld_i;
            if (vld_i) begin
                y_o     <= y_d;
                y_enc_o <= enc_d;
                any_o   <= all_any;
            end
        end
    end

`ifdef CZF_ASSERT_EN
    a_found_onehot: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        (vld_o && any_o) |-> ($onehot(y_o) && y_o[y_enc_o]));
    a_none_zero: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        (vld_o && !any_o) |-> (y_o == '0 && y_enc_o == '0));
    if ((1 << EW) == W) begin : g_pos_chk
        a_pos_range: assert property (@(posedge clk_i) disable iff (!arst_n_i)
            vld_i |-> (int'(pos_i) < W));
    end
`endif

endmodule

// File: tb/tb_circ_zero_find.sv
// Bench for circ_zero_find: directed W=16 cases plus randomized W=16/RADIX 4 and W=9/RADIX 2
// instances against a wrap-around scan model.
module tb_circ_zero_find;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_vld = 1'b0, a_vld_o, a_any;
    logic [15:0] a_x = '0, a_y;
    logic [3:0]  a_pos = '0, a_enc;

    logic        b_vld = 1'b0, b_vld_o, b_any;
    logic [8:0]  b_x = '0, b_y;
    logic [3:0]  b_pos = '0, b_enc;

    int tests = 0;
    int fails = 0;

    circ_zero_find #(.W(16), .RADIX_N(4)) dut_a (
        .clk_i (clk), .arst_n_i (arst_n), .vld_i (a_vld), .x_i (a_x), .pos_i (a_pos),
        .vld_o (a_vld_o), .y_o (a_y), .y_enc_o (a_enc), .any_o (a_any)
    );

    circ_zero_find #(.W(9), .RADIX_N(2)) dut_b (
        .clk_i (clk), .arst_n_i (arst_n), .vld_i (b_vld), .x_i (b_x), .pos_i (b_pos),
        .vld_o (b_vld_o), .y_o (b_y), .y_enc_o (b_enc), .any_o (b_any)
    );

    // Walk pos-1, pos-2, .., 0, w-1, .., pos and return the first zero index, or -1
    function automatic int ref_idx(input logic [63:0] x, input int pos, input int w);
        int p;
        p = (pos >= w) ? 0 : pos;
        for (int k = 1; k <= w; k++) begin
            int i;
            i = (p - k + w) % w;
            if (!x[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        a_x = 16'h1234; a_pos = 4'd3; a_vld = 1'b1;
        #2;
        tests++; if (a_vld_o !== 1'b0) begin fails++; $display("FAIL rst_vld got %b want 0", a_vld_o); end
        tests++; if (a_y !== 16'h0) begin fails++; $display("FAIL rst_y got %h want 0000", a_y); end
        tests++; if (a_enc !== 4'd0) begin fails++; $display("FAIL rst_enc got %0d want 0", a_enc); end
        tests++; if (a_any !== 1'b0) begin fails++; $display("FAIL rst_any got %b want 0", a_any); end
        tests++; if (b_vld_o !== 1'b0) begin fails++; $display("FAIL rst_b_vld got %b want 0", b_vld_o); end
        a_vld = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] dx [7] = '{16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h2A37, 16'hFFFF, 16'hFFFF};
        int          dp [7] = '{0, 0, 1, 15, 8, 0, 9};
        int          de [7] = '{0, 15, 0, 14, 7, -1, -1};
        logic [15:0] ey;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            a_x = dx[n]; a_pos = 4'(dp[n]); a_vld = 1'b1;
            @(negedge clk);
            ey = (de[n] < 0) ? 16'h0 : (16'h1 << de[n]);
            tests++; if (a_vld_o !== 1'b1) begin fails++; $display("FAIL dir%0d_vld got %b want 1", n, a_vld_o); end
            tests++; if (a_y !== ey) begin fails++; $display("FAIL dir%0d_y got %h want %h", n, a_y, ey); end
            tests++; if (a_enc !== 4'((de[n] < 0) ? 0 : de[n])) begin fails++; $display("FAIL dir%0d_enc got %0d want %0d", n, a_enc, de[n]); end
            tests++; if (a_any !== (de[n] >= 0)) begin fails++; $display("FAIL dir%0d_any got %b want %b", n, a_any, de[n] >= 0); end
        end
        a_vld = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        a_x = 16'h2A37; a_pos = 4'd8; a_vld = 1'b1;
        @(negedge clk);
        a_x = 16'h0000; a_pos = 4'd3; a_vld = 1'b0;
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b0) begin fails++; $display("FAIL hold_vld got %b want 0", a_vld_o); end
        tests++; if (a_y !== 16'h0080) begin fails++; $display("FAIL hold_y got %h want 0080", a_y); end
        tests++; if (a_enc !== 4'd7 || a_any !== 1'b1) begin fails++; $display("FAIL hold_enc got %0d/%b want 7/1", a_enc, a_any); end
        a_x = 16'hFFFF; a_vld = 1'b1;
        @(negedge clk);
        a_x = 16'h0000; a_vld = 1'b0;
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b0 || a_any !== 1'b0 || a_y !== 16'h0 || a_enc !== 4'd0) begin
            fails++; $display("FAIL hold_none got vld=%b any=%b y=%h enc=%0d want 0/0/0000/0", a_vld_o, a_any, a_y, a_enc);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a_x = 16'h0000; a_pos = 4'd1; a_vld = 1'b1;
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b1 || a_enc !== 4'd0) begin fails++; $display("FAIL mid_pre got vld=%b enc=%0d want 1/0", a_vld_o, a_enc); end
        a_x = 16'h2A37; a_pos = 4'd8;
        #2 arst_n = 1'b0;
        #1;
        tests++; if (a_vld_o !== 1'b0 || a_y !== 16'h0 || a_enc !== 4'd0 || a_any !== 1'b0) begin
            fails++; $display("FAIL mid_rst got vld=%b y=%h enc=%0d any=%b want all 0", a_vld_o, a_y, a_enc, a_any);
        end
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b0 || a_y !== 16'h0) begin fails++; $display("FAIL mid_held got vld=%b y=%h want 0/0000", a_vld_o, a_y); end
        arst_n = 1'b1;
        #1;
        tests++; if (a_vld_o !== 1'b0) begin fails++; $display("FAIL mid_rel got vld=%b want 0", a_vld_o); end
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b1 || a_y !== 16'h0080 || a_enc !== 4'd7 || a_any !== 1'b1) begin
            fails++; $display("FAIL mid_first got vld=%b y=%h enc=%0d any=%b want 1/0080/7/1", a_vld_o, a_y, a_enc, a_any);
        end
        a_x = 16'hFFFE; a_pos = 4'd0;
        @(negedge clk);
        tests++; if (a_vld_o !== 1'b1 || a_y !== 16'h0001 || a_enc !== 4'd0) begin
            fails++; $display("FAIL mid_b2b got vld=%b y=%h enc=%0d want 1/0001/0", a_vld_o, a_y, a_enc);
        end
        a_vld = 1'b0;
    endtask

    task automatic test_random();
        logic        ev_a, ev_b, ea_a, ea_b;
        logic [15:0] ey_a;
        logic [8:0]  ey_b;
        logic [3:0]  ee_a, ee_b;
        int          r;
        ev_a = 1'b0; ev_b = 1'b0; ea_a = 1'b0; ea_b = 1'b0;
        ey_a = '0; ey_b = '0; ee_a = '0; ee_b = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n > 0) begin
                tests++; if (a_vld_o !== ev_a || a_y !== ey_a || a_enc !== ee_a || a_any !== ea_a) begin
                    fails++; $display("FAIL rand_a%0d got %b/%h/%0d/%b want %b/%h/%0d/%b", n, a_vld_o, a_y, a_enc, a_any, ev_a, ey_a, ee_a, ea_a);
                end
                tests++; if (b_vld_o !== ev_b || b_y !== ey_b || b_enc !== ee_b || b_any !== ea_b) begin
                    fails++; $display("FAIL rand_b%0d got %b/%h/%0d/%b want %b/%h/%0d/%b", n, b_vld_o, b_y, b_enc, b_any, ev_b, ey_b, ee_b, ea_b);
                end
            end
            // bias toward dense vectors so wrap and no-zero cases appear often
            a_x = 16'($urandom) | ((n % 3 == 0) ? 16'($urandom) : 16'h0);
            if (n % 17 == 0) a_x = 16'hFFFF;
            b_x = 9'($urandom) | ((n % 2 == 0) ? 9'($urandom) : 9'h0);
            if (n % 13 == 0) b_x = 9'h1FF;
            a_pos = 4'($urandom_range(0, 15));
            b_pos = 4'($urandom_range(0, 15));
            a_vld = (n < 2) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            b_vld = (n < 2) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            ev_a = a_vld; ev_b = b_vld;
            if (a_vld) begin
                r = ref_idx(64'(a_x), int'(a_pos), 16);
                ea_a = (r >= 0); ey_a = (r >= 0) ? (16'h1 << r) : 16'h0; ee_a = (r >= 0) ? 4'(r) : 4'd0;
            end
            if (b_vld) begin
                r = ref_idx(64'(b_x), int'(b_pos), 9);
                ea_b = (r >= 0); ey_b = (r >= 0) ? (9'h1 << r) : 9'h0; ee_b = (r >= 0) ? 4'(r) : 4'd0;
            end
        end
        a_vld = 1'b0; b_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
